// File: rtl/clk_ce_synth.sv
// Multichannel fractional clock-enable synthesiser: one phase accumulator per
// channel, a single shadow slot for glitch-free frequency-word changes, and a lock flag.
module clk_ce_synth #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_CYCLES);

  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [ACC_W-1:0]  inc [NUM_CH];
  logic [ACC_W:0]    sum [NUM_CH];
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] apply_hit;

  logic              pend;
  logic              force_apply;
  logic [CH_W-1:0]   pend_ch;
  logic [ACC_W-1:0]  pend_inc;
  logic [LCNT_W-1:0] lcnt;
  logic [LCNT_W-1:0] lcnt_next;
  logic              accept;
  logic              ch_ok;

  // Config handshake: a word transfers on any edge where cfg_valid && cfg_ready;
  // cfg_ready is low exactly while the shadow slot holds an unapplied word.
  assign cfg_ready = !pend;
  assign accept    = cfg_valid && !pend;
  assign ch_ok     = int'(cfg_ch) < NUM_CH;

  // A pending word lands only at a wrap (or when the channel is idle/held/resynced),
  // so the outgoing period always completes and the next one starts from zero phase.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]       = {1'b0, acc[i]} + {1'b0, inc[i]};
      carry[i]     = sum[i][ACC_W];
      apply_hit[i] = pend && (int'(pend_ch) == i) &&
                     (carry[i] || (inc[i] == '0) || !enable || resync || force_apply);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
      ce_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (resync) begin
          acc[i]    <= '0;
          ce_out[i] <= 1'b0;
        end else if (enable) begin
          acc[i]    <= sum[i][ACC_W-1:0];
          ce_out[i] <= carry[i];
        end else begin
          ce_out[i] <= 1'b0;
        end
        if (apply_hit[i]) inc[i] <= pend_inc;
      end
    end
  end

  // Words captured on a resync edge miss that edge's apply, so force them next edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      force_apply <= 1'b0;
      pend_ch     <= '0;
      pend_inc    <= '0;
    end else begin
      force_apply <= 1'b0;
      if (accept) begin
        pend        <= ch_ok;
        pend_ch     <= cfg_ch;
        pend_inc    <= cfg_inc;
        force_apply <= resync && ch_ok;
      end else if (|apply_hit) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    lcnt_next = lcnt;
    if (accept || resync || !enable) lcnt_next = '0;
    else if (!pend && (lcnt != LCNT_MAX)) lcnt_next = lcnt + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt   <= '0;
      locked <= 1'b0;
    end else begin
      lcnt   <= lcnt_next;
      locked <= (lcnt_next == LCNT_MAX);
    end
  end

endmodule

// File: tb/tb_clk_ce_synth.sv
// Bench for clk_ce_synth: directed scenarios plus randomized traffic, all checked
// against an integer phase model with a one-entry pending-word slot.
module tb_clk_ce_synth;

  localparam int NCH  = 2;
  localparam int AW   = 8;
  localparam int LOCK = 4;
  localparam int MOD  = 1 << AW;

  logic          refclk;
  logic          rst_n;
  logic          enable;
  logic          resync;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_ch;
  logic [AW-1:0] cfg_inc;
  logic [NCH-1:0] ce_out;
  logic          locked;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  clk_ce_synth #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LOCK)) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .resync    (resync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .ce_out    (ce_out),
    .locked    (locked)
  );

  // clock / watchdog
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: phase as plain integers mod 2^AW, one-entry pending slot
  int       phase [NCH];
  int       rate  [NCH];
  bit       m_pend;
  int       m_pch;
  int       m_pinc;
  bit       m_force;
  int       m_stable;
  bit       m_locked;
  bit [NCH-1:0] m_ce;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      phase[c] = 0;
      rate[c]  = 0;
    end
    m_pend = 0; m_pch = 0; m_pinc = 0; m_force = 0;
    m_stable = 0; m_locked = 0; m_ce = '0;
  endtask

  task automatic model_step();
    bit took;
    bit applied;
    bit wrapped;
    took    = cfg_valid && !m_pend;
    applied = 0;
    for (int c = 0; c < NCH; c++) begin
      wrapped = 0;
      if (resync) phase[c] = 0;
      else if (enable) begin
        phase[c] = phase[c] + rate[c];
        if (phase[c] >= MOD) begin
          phase[c] = phase[c] - MOD;
          wrapped  = 1;
        end
      end
      m_ce[c] = wrapped;
      if (m_pend && m_pch == c &&
          (wrapped || rate[c] == 0 || !enable || resync || m_force)) begin
        rate[c] = m_pinc;
        applied = 1;
      end
    end
    if (took || resync || !enable) m_stable = 0;
    else if (!m_pend && m_stable < LOCK) m_stable++;
    m_locked = (m_stable == LOCK);
    if (took) begin
      m_pend  = (int'(cfg_ch) < NCH);
      m_pch   = int'(cfg_ch);
      m_pinc  = int'(cfg_inc);
      m_force = resync && m_pend;
    end else begin
      m_force = 0;
      if (applied) m_pend = 0;
    end
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the edge, outputs checked at the same point
  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    cyc++;
    check("ce_out", 32'(ce_out), 32'(m_ce));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    check("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic cfg_write(input int ch, input int inc_val);
    bit ok;
    int n;
    cfg_valid = 1'b1;
    cfg_ch    = ch[0];
    cfg_inc   = inc_val[AW-1:0];
    n = 0;
    do begin
      ok = cfg_ready;
      tick();
      n++;
    end while (!ok && n < 64);
    cfg_valid = 1'b0;
    if (!ok) check("cfg_accept_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int cnt;
    int prev;
    bit any_ce;
    rst_n = 1'b0; enable = 1'b0; resync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_inc = '0;
    model_reset();
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
    check("rst_ce", 32'(ce_out), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    check("rst_locked", 32'(locked), 32'(0));

    // 1: run with no config
    enable = 1'b1;
    repeat (3) tick();
    check("t1_not_yet_locked", 32'(locked), 32'(0));
    tick();
    check("t1_locked", 32'(locked), 32'(1));
    repeat (2) tick();

    // 2: ch0 inc 0x40, first strobe after E5, then every 4
    cfg_write(0, 'h40);
    check("t2_lock_drop", 32'(locked), 32'(0));
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t2_ce0", 32'(ce_out[0]), 32'(k == 5));
    end
    check("t2_locked", 32'(locked), 32'(1));
    repeat (3) tick();
    check("t2_gap0", 32'(ce_out[0]), 32'(0));
    tick();
    check("t2_period", 32'(ce_out[0]), 32'(1));

    // 3: ch1 inc 0x60, 3 strobes per 8 cycles
    cfg_write(1, 'h60);
    repeat (4) tick();
    cnt = 0;
    repeat (16) begin
      tick();
      if (ce_out[1]) cnt++;
    end
    check("t3_ch1_count16", 32'(cnt), 32'(6));

    // 4: ch0 to 0x80 mid-period, second write held until the slot frees
    tick();
    cfg_write(0, 'h80);
    cfg_write(1, 'h20);
    prev = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ce_out[0]) begin
        if (prev >= 0) check("t4_gap", 32'(cyc - prev), 32'(2));
        prev = cyc;
      end
    end
    check("t4_saw_strobes", 32'(prev >= 0), 32'(1));

    // 5: resync with ch0 back at 0x40
    cfg_write(0, 'h40);
    repeat (12) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("t5_no_ce", 32'(ce_out), 32'(0));
    check("t5_lock_drop", 32'(locked), 32'(0));
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t5_ce0", 32'(ce_out[0]), 32'(k == 4));
      check("t5_locked", 32'(locked), 32'(k == 4));
    end
    // resync coinciding with an accept
    resync = 1'b1;
    cfg_write(1, 'h50);
    resync = 1'b0;
    repeat (10) tick();

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      enable    = ($urandom_range(0, 7) != 0);
      resync    = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_inc   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(128, 255))
                                              : AW'($urandom_range(0, 64));
      tick();
    end
    enable = 1'b1; resync = 1'b0; cfg_valid = 1'b0;
    repeat (4) tick();

    // 6: async reset with a word pending
    cfg_write(0, 'h10);
    repeat (20) tick();
    cfg_write(0, 'hf0);
    check("t6_pending", 32'(cfg_ready), 32'(0));
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_ce", 32'(ce_out), 32'(0));
    check("t6_rst_locked", 32'(locked), 32'(0));
    check("t6_rst_ready", 32'(cfg_ready), 32'(1));
    @(negedge refclk);
    rst_n  = 1'b1;
    enable = 1'b1;
    any_ce = 1'b0;
    repeat (300) begin
      tick();
      if (ce_out != '0) any_ce = 1'b1;
    end
    check("t6_never_strobes", 32'(any_ce), 32'(0));
    check("t6_relocked", 32'(locked), 32'(1));

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
